// File: rtl/m68_bus_master_if.sv
// 68000-style bus signals between the bus initiator (master) and a responder (slave).
// Strobes (as/uds/lds) are active low; dtack high means accepted, falling means done.
interface m68_bus_master_if;
    logic        M68_as;
    logic        M68_rw;
    logic        M68_uds;
    logic        M68_lds;
    logic [31:0] M68_addr;
    logic [15:0] M68_data_out;
    logic [15:0] M68_data_in;
    logic        M68_dtack;

    modport master (
        output M68_as,
        output M68_rw,
        output M68_uds,
        output M68_lds,
        output M68_addr,
        output M68_data_out,
        input  M68_data_in,
        input  M68_dtack
    );

    modport slave (
        input  M68_as,
        input  M68_rw,
        input  M68_uds,
        input  M68_lds,
        input  M68_addr,
        input  M68_data_out,
        output M68_data_in,
        output M68_dtack
    );
endinterface

// File: rtl/m68_bus_master.sv
// 68000-style bus initiator: one host word request -> one AS/UDS/LDS cycle closed by DTACK.
// Optional bus-error timeout is enabled by defining M68_BUS_TIMEOUT_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | bus released, waiting for req
// ST_SETUP     | addr/rw/data driven, AS still high for SETUP_CYCLES
// ST_STROBE    | AS and data strobes low, waiting for dtack to rise
// ST_WAIT_DONE | responder accepted, waiting for dtack to fall
// ST_RELEASE   | strobes released, ack (and err on timeout) pulsing
module m68_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned SETUP_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    req_rw,
    input  logic [23:0]             req_addr,
    input  logic [15:0]             req_wdata,
    input  logic [1:0]              req_be,
    output logic                    ack,
    output logic                    err,
    output logic [15:0]             rdata,
    output logic                    busy,
    m68_bus_master_if.master        bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_STROBE    = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RELEASE   = 3'd4;

    localparam int unsigned        SETUP_W    = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);

    if (SETUP_CYCLES < 1) begin : g_bad_setup
        $error("m68_bus_master: SETUP_CYCLES must be at least 1");
    end
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_timeout
        $error("m68_bus_master: TIMEOUT_CYCLES must be within 2..65536");
    end

    logic [2:0]         state;
    logic               rd_q;
    logic [1:0]         be_q;
    logic [SETUP_W-1:0] setup_cnt;
    logic               setup_done;
    logic               tmo_fire;
    logic               addr_lsb_unused;

    // Word cycles only: the byte address LSB never reaches the bus.
    assign addr_lsb_unused = req_addr[0];

    assign setup_done = (state == ST_SETUP) && (setup_cnt == '0);

`ifdef M68_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        in_cycle;

    assign in_cycle = (state == ST_STROBE) || (state == ST_WAIT_DONE);

    // A genuine completion on the last allowed cycle wins over the timeout.
    assign tmo_fire = in_cycle && (tmo_cnt == TMO_LAST) &&
                      !((state == ST_WAIT_DONE) && !bus.M68_dtack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= tmo_fire;
            if (setup_done) begin
                tmo_cnt <= '0;
            end else if (in_cycle) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            bus.M68_as       <= 1'b1;
            bus.M68_rw       <= 1'b1;
            bus.M68_uds      <= 1'b1;
            bus.M68_lds      <= 1'b1;
            bus.M68_addr     <= '0;
            bus.M68_data_out <= '0;
            rd_q             <= 1'b1;
            be_q             <= 2'b11;
            setup_cnt        <= '0;
            ack              <= 1'b0;
            rdata            <= '0;
            busy             <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        bus.M68_addr     <= {8'h00, req_addr[23:1], 1'b0};
                        bus.M68_rw       <= req_rw;
                        bus.M68_data_out <= req_wdata;
                        rd_q             <= req_rw;
                        be_q             <= (req_be == 2'b00) ? 2'b11 : req_be;
                        setup_cnt        <= SETUP_LOAD;
                        busy             <= 1'b1;
                        state            <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (setup_done) begin
                        bus.M68_as  <= 1'b0;
                        bus.M68_uds <= rd_q ? 1'b0 : ~be_q[1];
                        bus.M68_lds <= rd_q ? 1'b0 : ~be_q[0];
                        state       <= ST_STROBE;
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (tmo_fire) begin
                        bus.M68_as  <= 1'b1;
                        bus.M68_uds <= 1'b1;
                        bus.M68_lds <= 1'b1;
                        bus.M68_rw  <= 1'b1;
                        ack         <= 1'b1;
                        state       <= ST_RELEASE;
                    end else if (bus.M68_dtack) begin
                        state <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!bus.M68_dtack) begin
                        if (rd_q) begin
                            rdata <= bus.M68_data_in;
                        end
                        bus.M68_as  <= 1'b1;
                        bus.M68_uds <= 1'b1;
                        bus.M68_lds <= 1'b1;
                        bus.M68_rw  <= 1'b1;
                        ack         <= 1'b1;
                        state       <= ST_RELEASE;
                    end else if (tmo_fire) begin
                        bus.M68_as  <= 1'b1;
                        bus.M68_uds <= 1'b1;
                        bus.M68_lds <= 1'b1;
                        bus.M68_rw  <= 1'b1;
                        ack         <= 1'b1;
                        state       <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    bus.M68_as  <= 1'b1;
                    bus.M68_uds <= 1'b1;
                    bus.M68_lds <= 1'b1;
                    bus.M68_rw  <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68_bus_master.sv
// Bench for m68_bus_master: behavioural responder with its own memory, reference memory
// model, and an ack scoreboard; the timeout scenario follows M68_BUS_TIMEOUT_EN.
module tb_m68_bus_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = 2'b11;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;

    m68_bus_master_if bus ();

    m68_bus_master #(
        .TIMEOUT_CYCLES(TMO),
        .SETUP_CYCLES  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          ack_cyc;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
    } bus_t;

    sb_t         sb_q[$];
    bus_t        bus_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] rsp_mem[int];
    logic [15:0] last_rd = '0;
    int          rsp_dly = 1;
    bit          rsp_stuck = 1'b0;
    int          accepts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ack scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin : ack_monitor
        sb_t s;
        if (rst_n && ack) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 err=%0b want no ack (cycle %0d)", err, cyc);
            end else begin
                s = sb_q.pop_front();
                check("ack_err", err, s.err);
                check("rdata", rdata, s.rdata);
                if (s.ack_cyc >= 0) check("ack_latency", cyc, s.ack_cyc);
            end
        end
    end

    // AS must stay high at least two cycles between consecutive strobes.
    int as_hi = 0;
    always @(negedge clk) begin
        if (bus.M68_as) begin
            as_hi++;
        end else begin
            if (as_hi > 0) begin
                total++;
                if (as_hi < 2) begin
                    bad++;
                    $display("FAIL as_gap: got %0d high cycles want >= 2", as_hi);
                end
            end
            as_hi = 0;
        end
    end

    // Responder: accepts each AS fall once, raises dtack after rsp_dly cycles, drops it 2 later.
    initial begin : responder
        bus_t e;
        int   key;
        int   n;
        bus.M68_dtack   = 1'b0;
        bus.M68_data_in = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && !bus.M68_as) begin
                accepts++;
                e.addr = bus.M68_addr; e.rw = bus.M68_rw; e.wdata = bus.M68_data_out;
                e.uds = bus.M68_uds; e.lds = bus.M68_lds;
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: got strobe at addr %0h want none", bus.M68_addr);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_addr", bus.M68_addr, e.addr);
                    check("bus_rw", bus.M68_rw, e.rw);
                    check("bus_uds", bus.M68_uds, e.uds);
                    check("bus_lds", bus.M68_lds, e.lds);
                    if (!e.rw) check("bus_wdata", bus.M68_data_out, e.wdata);
                end
                key = int'(bus.M68_addr[23:1]);
                if (!rsp_stuck) begin
                    repeat (rsp_dly) @(posedge clk);
                    #1;
                    bus.M68_dtack   = 1'b1;
                    bus.M68_data_in = (bus.M68_rw) ?
                        (rsp_mem.exists(key) ? rsp_mem[key] : 16'h0000) : 16'($urandom);
                    repeat (2) @(posedge clk);
                    #1;
                    check("hold_addr", bus.M68_addr, e.addr);
                    check("hold_strobes", {bus.M68_as, bus.M68_uds, bus.M68_lds}, {1'b0, e.uds, e.lds});
                    if (!bus.M68_rw) begin
                        check("hold_wdata", bus.M68_data_out, e.wdata);
                        if (!rsp_mem.exists(key)) rsp_mem[key] = 16'h0000;
                        if (!bus.M68_uds) rsp_mem[key][15:8] = bus.M68_data_out[15:8];
                        if (!bus.M68_lds) rsp_mem[key][7:0]  = bus.M68_data_out[7:0];
                    end
                    bus.M68_dtack = 1'b0;
                end
                n = 0;
                while (!bus.M68_as && n < 300) begin
                    @(posedge clk); #1;
                    n++;
                end
                bus.M68_dtack = 1'b0;
            end
        end
    end

    // Drive one request, model its effect, and wait until the DUT takes it.
    task automatic issue(input logic rw, input logic [23:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input bit hold, input bit exp_ack,
                         input bit chk_lat, input bit exp_err);
        int          n = 0;
        int          key;
        bus_t        b;
        sb_t         s;
        logic [1:0]  eb;
        logic [15:0] cur;
        req_rw = rw; req_addr = a; req_wdata = wd; req_be = be; req = 1'b1;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_wait: got busy=1 want idle within 300 cycles");
            req = 1'b0;
            return;
        end
        eb      = (be == 2'b00) ? 2'b11 : be;
        key     = int'(a[23:1]);
        b.addr  = {8'h00, a[23:1], 1'b0};
        b.rw    = rw;
        b.uds   = rw ? 1'b0 : !eb[1];
        b.lds   = rw ? 1'b0 : !eb[0];
        b.wdata = wd;
        bus_q.push_back(b);
        cur = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        if (!rw && exp_ack && !exp_err) begin
            if (eb[1]) cur[15:8] = wd[15:8];
            if (eb[0]) cur[7:0]  = wd[7:0];
            ref_mem[key] = cur;
        end
        s.err   = exp_err;
        s.rdata = (rw && !exp_err) ? cur : last_rd;
        @(posedge clk); #1;
        check("accept_busy", busy, 1'b1);
        if (exp_ack) begin
            last_rd   = s.rdata;
            s.ack_cyc = chk_lat ? (cyc + (exp_err ? TMO + 1 : 5)) : -1;
            sb_q.push_back(s);
        end
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0 || busy) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d acks pending busy=%0b want none", sb_q.size(), busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_strobes", {bus.M68_as, bus.M68_uds, bus.M68_lds}, 3'b111);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 16'h0000);
        bus_q.delete();
        last_rd = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   base_acc;
        logic rw;
        logic [1:0] be;
        logic [23:0] a;
        repeat (3) @(posedge clk);
        #1;
        check("reset_as", bus.M68_as, 1'b1);
        check("reset_uds_lds", {bus.M68_uds, bus.M68_lds}, 2'b11);
        check("reset_rw", bus.M68_rw, 1'b1);
        check("reset_addr", bus.M68_addr, 32'h0);
        check("reset_data_out", bus.M68_data_out, 16'h0);
        check("reset_ack_err", {ack, err}, 2'b00);
        check("reset_rdata", rdata, 16'h0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read with fixed responder timing: ack lands 5 edges after acceptance.
        rsp_dly = 1;
        rsp_mem[int'(24'h001234 >> 1)] = 16'hBEEF;
        ref_mem[int'(24'h001234 >> 1)] = 16'hBEEF;
        issue(1'b1, 24'h001234, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // Byte write to the lower lane, then read it back; be=00 acts as a full word.
        issue(1'b0, 24'hC00004, 16'h8F02, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        issue(1'b1, 24'hC00005, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        issue(1'b0, 24'hC00006, 16'hA55A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 24'hC00006, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-to-back reads with req held high.
        base_acc = accepts;
        issue(1'b1, 24'h001234, 16'h0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 24'hC00004, 16'h0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 24'hC00006, 16'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        check("b2b_accepts", accepts - base_acc, 3);

        // Randomized traffic over a small address window so reads hit earlier writes.
        for (int batch = 0; batch < 6; batch++) begin
            rsp_dly = int'($urandom_range(1, 4));
            for (int k = 0; k < 8; k++) begin
                rw = 1'($urandom);
                be = 2'($urandom);
                a  = {8'h20, 12'h000, 3'($urandom), 1'($urandom)};
                issue(rw, a, 16'($urandom), be, (k != 7) && ($urandom_range(0, 1) == 1),
                      1'b1, 1'b0, 1'b0);
            end
            drain();
        end

        // Slow responder.
        rsp_dly = 10;
        issue(1'b0, 24'h3000A0, 16'h1357, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 24'h3000A0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        rsp_dly = 1;

        // Responder that never answers.
        rsp_stuck = 1'b1;
`ifdef M68_BUS_TIMEOUT_EN
        issue(1'b1, 24'h001234, 16'h0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();
        check("tmo_released", {bus.M68_as, bus.M68_uds, bus.M68_lds, busy}, 4'b1110);
`else
        issue(1'b1, 24'h001234, 16'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("no_tmo_busy", busy, 1'b1);
        check("no_tmo_as", bus.M68_as, 1'b0);
        do_reset();
`endif

        // Reset in the middle of a strobe: strobes drop away, no ack.
        issue(1'b1, 24'h001234, 16'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_strobe_as", bus.M68_as, 1'b0);
        do_reset();
        rsp_stuck = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Bus is usable again after the abort.
        issue(1'b1, 24'h001234, 16'h0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        check("pending_acks", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
